riscv_stage_ctrl: RTL and testbench

RISCV_STAGE_CTRL -- requirements
Module: riscv_stage_ctrl

---
 rtl/riscv_stage_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_riscv_stage_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_stage_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// riscv_stage_ctrl
//   Multi-cycle RISC-V stage sequencer. It steps one instruction at a time
//   through FETCH -> DECODE -> EXECUTE -> (MEM_WAIT) -> WRITE_BACK.
//   It times out stalled fetches and memory accesses into ERROR, parks in
//   HALT on EBREAK, and keeps a running-cycle counter and a retired-instruction
//   counter.
//
// Parameters
//   CNT_W    width of cycle_count / instret_count (both wrap modulo 2^CNT_W)
//   TIMEOUT  consecutive wait cycles before ERROR; 0 disables the timeout
//   BOOT_RUN 1: reset exits to FETCH, 0: reset exits to IDLE
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   start               leave IDLE / resume from HALT
//   fetch_rdy           instruction word valid
//   is_ebreak/is_load/is_store  instruction class, sampled in EXECUTE
//   data_read_rdy       load data returned
//   data_write_rdy      store accepted
//   cnt_clear           zero both counters
//   fetch..write_back   one-hot stage strobes (registered, Moore)
//   retire              instruction retired this cycle (WRITE_BACK)
//   halted, bus_error   core in HALT / ERROR
//   state               encoded current state
//   cycle_count         cycles spent in FETCH..WRITE_BACK
//   instret_count       retired instructions
// -----------------------------------------------------------------------------
module riscv_stage_ctrl #(
  parameter int CNT_W    = 64,
  parameter int TIMEOUT  = 255,
  parameter bit BOOT_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fetch_rdy,
  input  logic             is_ebreak,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             data_read_rdy,
  input  logic             data_write_rdy,
  input  logic             cnt_clear,
  output logic             fetch,
  output logic             decode,
  output logic             execute,
  output logic             mem_wait,
  output logic             write_back,
  output logic             retire,
  output logic             halted,
  output logic             bus_error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_DECODE     = 3'd2,
    S_EXECUTE    = 3'd3,
    S_MEM_WAIT   = 3'd4,
    S_WRITE_BACK = 3'd5,
    S_HALT       = 3'd6,
    S_ERROR      = 3'd7
  } state_e;

  // Wait counter only has to reach TIMEOUT-1; keep at least one bit so a
  // disabled timeout still yields a legal vector.
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam state_e RESET_STATE = state_e'(BOOT_RUN ? 3'd1 : 3'd0);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               kind_load_q, kind_load_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [7:0]         out_q, out_d;
  logic               wait_inc_s;
  logic               timeout_hit_s;
  logic               mem_done_s;
  logic               running_s;

  // Output vector {fetch, decode, execute, mem_wait, write_back, retire,
  // halted, bus_error} for a given state.
  function automatic logic [7:0] stage_outputs(input state_e s);
    logic [7:0] v;
    case (s)
      S_FETCH:      v = 8'b1000_0000;
      S_DECODE:     v = 8'b0100_0000;
      S_EXECUTE:    v = 8'b0010_0000;
      S_MEM_WAIT:   v = 8'b0001_0000;
      S_WRITE_BACK: v = 8'b0000_1100;
      S_HALT:       v = 8'b0000_0010;
      S_ERROR:      v = 8'b0000_0001;
      default:      v = 8'b0000_0000;
    endcase
    return v;
  endfunction

  // Qualifiers for the stall states.
  always_comb begin
    timeout_hit_s = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
    // Both-flags instructions were latched as loads in EXECUTE.
    mem_done_s    = kind_load_q ? data_read_rdy : data_write_rdy;
    running_s     = (state_q == S_FETCH)    || (state_q == S_DECODE) ||
                    (state_q == S_EXECUTE)  || (state_q == S_MEM_WAIT) ||
                    (state_q == S_WRITE_BACK);
  end

  // Next-state logic; a ready seen together with the timeout still advances.
  always_comb begin
    state_d     = state_q;
    kind_load_d = kind_load_q;
    wait_inc_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        if (fetch_rdy) begin
          state_d = S_DECODE;
        end else if (timeout_hit_s) begin
          state_d = S_ERROR;
        end else begin
          state_d    = S_FETCH;
          wait_inc_s = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        kind_load_d = is_load;
        if (is_ebreak)                state_d = S_HALT;
        else if (is_load || is_store) state_d = S_MEM_WAIT;
        else                          state_d = S_WRITE_BACK;
      end
      S_MEM_WAIT: begin
        if (mem_done_s) begin
          state_d = S_WRITE_BACK;
        end else if (timeout_hit_s) begin
          state_d = S_ERROR;
        end else begin
          state_d    = S_MEM_WAIT;
          wait_inc_s = 1'b1;
        end
      end
      S_WRITE_BACK: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_HALT;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  // Wait counter restarts on every state change.
  always_comb begin
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (wait_inc_s) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end
  end

  // Counter next values; clear beats increment.
  always_comb begin
    if (cnt_clear) begin
      cycle_d   = '0;
      instret_d = '0;
    end else begin
      if (running_s) cycle_d = cycle_q + CNT_W'(1);
      else           cycle_d = cycle_q;
      if (state_q == S_WRITE_BACK) instret_d = instret_q + CNT_W'(1);
      else                         instret_d = instret_q;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    out_d = stage_outputs(state_d);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RESET_STATE;
      wait_q      <= '0;
      kind_load_q <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
      out_q       <= stage_outputs(RESET_STATE);
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      kind_load_q <= kind_load_d;
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      out_q       <= out_d;
    end
  end

  assign {fetch, decode, execute, mem_wait, write_back, retire, halted, bus_error} = out_q;
  assign state         = state_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_riscv_stage_ctrl.sv
`timescale 1ns/1ps
// Bench for riscv_stage_ctrl: two instances with different parameters
// (u0: CNT_W=8, TIMEOUT=5, BOOT_RUN=1; u1: CNT_W=4, TIMEOUT=0, BOOT_RUN=0),
// each tracked cycle by cycle by a behavioural model, plus directed scenarios.
module tb_riscv_stage_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic in_rst[2], in_start[2], in_frdy[2], in_ebreak[2], in_load[2], in_store[2];
  logic in_drdy[2], in_dwrdy[2], in_clr[2];
  logic o_fetch[2], o_decode[2], o_execute[2], o_mem[2], o_wb[2], o_retire[2];
  logic o_halted[2], o_berr[2];
  logic [2:0] o_state[2];
  logic [7:0] cyc0, ret0;
  logic [3:0] cyc1, ret1;

  int n_assert = 0;
  int n_fail   = 0;

  // Parameters of each instance, as seen by the model.
  int P_W[2] = '{8, 4};
  int P_T[2] = '{5, 0};
  int P_B[2] = '{1, 0};

  // Model state: 0 IDLE 1 FETCH 2 DECODE 3 EXECUTE 4 MEM_WAIT 5 WRITE_BACK 6 HALT 7 ERROR
  int m_state[2], m_wait[2], m_kind[2];
  longint unsigned m_cyc[2], m_ret[2];

  riscv_stage_ctrl #(.CNT_W(8), .TIMEOUT(5), .BOOT_RUN(1'b1)) u0 (
    .clk(clk), .rst(in_rst[0]), .start(in_start[0]), .fetch_rdy(in_frdy[0]),
    .is_ebreak(in_ebreak[0]), .is_load(in_load[0]), .is_store(in_store[0]),
    .data_read_rdy(in_drdy[0]), .data_write_rdy(in_dwrdy[0]), .cnt_clear(in_clr[0]),
    .fetch(o_fetch[0]), .decode(o_decode[0]), .execute(o_execute[0]), .mem_wait(o_mem[0]),
    .write_back(o_wb[0]), .retire(o_retire[0]), .halted(o_halted[0]), .bus_error(o_berr[0]),
    .state(o_state[0]), .cycle_count(cyc0), .instret_count(ret0));

  riscv_stage_ctrl #(.CNT_W(4), .TIMEOUT(0), .BOOT_RUN(1'b0)) u1 (
    .clk(clk), .rst(in_rst[1]), .start(in_start[1]), .fetch_rdy(in_frdy[1]),
    .is_ebreak(in_ebreak[1]), .is_load(in_load[1]), .is_store(in_store[1]),
    .data_read_rdy(in_drdy[1]), .data_write_rdy(in_dwrdy[1]), .cnt_clear(in_clr[1]),
    .fetch(o_fetch[1]), .decode(o_decode[1]), .execute(o_execute[1]), .mem_wait(o_mem[1]),
    .write_back(o_wb[1]), .retire(o_retire[1]), .halted(o_halted[1]), .bus_error(o_berr[1]),
    .state(o_state[1]), .cycle_count(cyc1), .instret_count(ret1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model of instance i by one clock using its current inputs.
  task automatic model_step(input int i);
    int s, ns;
    bit ok;
    longint unsigned mask;
    mask = (64'd1 << P_W[i]) - 64'd1;
    s = m_state[i];
    if (!in_rst[i]) begin
      m_state[i] = (P_B[i] != 0) ? 1 : 0;
      m_wait[i] = 0; m_kind[i] = 0; m_cyc[i] = 0; m_ret[i] = 0;
    end else begin
      ns = s;
      case (s)
        0: if (in_start[i]) ns = 1;
        1: if (in_frdy[i]) ns = 2;
           else if (P_T[i] != 0 && m_wait[i] + 1 == P_T[i]) ns = 7;
        2: ns = 3;
        3: begin
             m_kind[i] = in_load[i] ? 1 : 0;
             if (in_ebreak[i]) ns = 6;
             else if (in_load[i] || in_store[i]) ns = 4;
             else ns = 5;
           end
        4: begin
             ok = (m_kind[i] != 0) ? in_drdy[i] : in_dwrdy[i];
             if (ok) ns = 5;
             else if (P_T[i] != 0 && m_wait[i] + 1 == P_T[i]) ns = 7;
           end
        5: ns = 1;
        6: if (in_start[i]) ns = 1;
        default: ns = 7;
      endcase
      if (in_clr[i]) begin
        m_cyc[i] = 0; m_ret[i] = 0;
      end else begin
        if (s >= 1 && s <= 5) m_cyc[i] = (m_cyc[i] + 1) & mask;
        if (s == 5) m_ret[i] = (m_ret[i] + 1) & mask;
      end
      if (ns != s) m_wait[i] = 0;
      else if (s == 1 || s == 4) m_wait[i] = m_wait[i] + 1;
      m_state[i] = ns;
    end
  endtask

  task automatic check_dut(input int i);
    int s;
    logic [10:0] obs, exp;
    logic [63:0] oc, orr;
    s = m_state[i];
    exp = {s == 1, s == 2, s == 3, s == 4, s == 5, s == 5, s == 6, s == 7, 3'(s)};
    obs = {o_fetch[i], o_decode[i], o_execute[i], o_mem[i], o_wb[i], o_retire[i],
           o_halted[i], o_berr[i], o_state[i]};
    oc  = (i == 0) ? {56'd0, cyc0} : {60'd0, cyc1};
    orr = (i == 0) ? {56'd0, ret0} : {60'd0, ret1};
    chk($sformatf("u%0d_outputs", i), {53'd0, obs}, {53'd0, exp});
    chk($sformatf("u%0d_cycle_count", i), oc, m_cyc[i]);
    chk($sformatf("u%0d_instret_count", i), orr, m_ret[i]);
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic quiet(input int i);
    in_start[i] = 1'b0; in_frdy[i] = 1'b0; in_ebreak[i] = 1'b0; in_load[i] = 1'b0;
    in_store[i] = 1'b0; in_drdy[i] = 1'b0; in_dwrdy[i] = 1'b0; in_clr[i] = 1'b0;
  endtask

  initial begin
    quiet(0); quiet(1);
    in_rst[0] = 1'b0; in_rst[1] = 1'b0;
    step();
    chk("reset_u0_fetch", {61'd0, o_state[0]}, 64'd1);
    chk("reset_u0_cycle", {56'd0, cyc0}, 64'd0);
    chk("reset_u1_idle", {61'd0, o_state[1]}, 64'd0);
    chk("reset_u0_retire", {63'd0, o_retire[0]}, 64'd0);

    // ALU instruction: F, D, E, WB.
    in_rst[0] = 1'b1;
    in_frdy[0] = 1'b1; step(); in_frdy[0] = 1'b0;
    step(); step();
    chk("alu_retire", {63'd0, o_retire[0]}, 64'd1);
    step();
    chk("alu_cycle", {56'd0, cyc0}, 64'd4);
    chk("alu_instret", {56'd0, ret0}, 64'd1);

    // Load (both flags -> load), read ready low 3 MEM_WAIT cycles.
    in_frdy[0] = 1'b1; step(); in_frdy[0] = 1'b0; step();
    in_load[0] = 1'b1; in_store[0] = 1'b1; step();
    in_load[0] = 1'b0; in_store[0] = 1'b0;
    in_dwrdy[0] = 1'b1; step(); in_dwrdy[0] = 1'b0;
    step(); step();
    chk("load_still_wait", {61'd0, o_state[0]}, 64'd4);
    in_drdy[0] = 1'b1; step(); in_drdy[0] = 1'b0;
    chk("load_wb", {61'd0, o_state[0]}, 64'd5);
    step();
    chk("load_instret", {56'd0, ret0}, 64'd2);
    chk("load_cycle", {56'd0, cyc0}, 64'd12);

    // Store with write ready stuck low -> ERROR after 5 MEM_WAIT cycles.
    in_frdy[0] = 1'b1; step(); in_frdy[0] = 1'b0; step();
    in_store[0] = 1'b1; step(); in_store[0] = 1'b0;
    repeat (4) step();
    chk("store_wait5", {61'd0, o_state[0]}, 64'd4);
    step();
    chk("store_timeout_err", {63'd0, o_berr[0]}, 64'd1);
    in_start[0] = 1'b1; repeat (3) step(); in_start[0] = 1'b0;
    chk("err_ignores_start", {61'd0, o_state[0]}, 64'd7);
    chk("err_cycle_frozen", {56'd0, cyc0}, 64'd20);
    in_rst[0] = 1'b0; step(); in_rst[0] = 1'b1;
    chk("err_reset_fetch", {61'd0, o_state[0]}, 64'd1);
    chk("err_reset_cnt", {56'd0, cyc0}, 64'd0);

    // Ready arriving on the timeout cycle wins.
    in_frdy[0] = 1'b1; step(); in_frdy[0] = 1'b0; step();
    in_store[0] = 1'b1; step(); in_store[0] = 1'b0;
    repeat (4) step();
    in_dwrdy[0] = 1'b1; step(); in_dwrdy[0] = 1'b0;
    chk("ready_wins_timeout", {61'd0, o_state[0]}, 64'd5);
    step();

    // EBREAK (with is_load also set) -> HALT, no retire, cycles frozen.
    in_frdy[0] = 1'b1; step(); in_frdy[0] = 1'b0; step();
    in_ebreak[0] = 1'b1; in_load[0] = 1'b1; step();
    in_ebreak[0] = 1'b0; in_load[0] = 1'b0;
    chk("ebreak_halted", {63'd0, o_halted[0]}, 64'd1);
    repeat (3) step();
    chk("halt_cycle_frozen", {56'd0, cyc0}, 64'd12);
    chk("halt_no_retire", {56'd0, ret0}, 64'd1);
    in_start[0] = 1'b1; step(); in_start[0] = 1'b0;
    chk("halt_resume", {61'd0, o_state[0]}, 64'd1);

    // Fetch timeout.
    repeat (5) step();
    chk("fetch_timeout", {61'd0, o_state[0]}, 64'd7);
    in_rst[0] = 1'b0; step(); in_rst[0] = 1'b1;

    // u1: BOOT_RUN=0 stays IDLE, then 16 ALU instructions wrap a 4-bit counter.
    in_rst[1] = 1'b1;
    repeat (3) step();
    chk("idle_hold", {61'd0, o_state[1]}, 64'd0);
    chk("idle_cycle_zero", {60'd0, cyc1}, 64'd0);
    in_start[1] = 1'b1; step(); in_start[1] = 1'b0;
    chk("idle_start", {61'd0, o_state[1]}, 64'd1);
    in_frdy[1] = 1'b1;
    repeat (64) step();
    chk("wrap_instret", {60'd0, ret1}, 64'd0);
    chk("wrap_cycle", {60'd0, cyc1}, 64'd0);
    step(); step(); step();
    chk("clr_in_wb", {61'd0, o_state[1]}, 64'd5);
    in_clr[1] = 1'b1; step(); in_clr[1] = 1'b0;
    chk("clr_cycle", {60'd0, cyc1}, 64'd0);
    chk("clr_instret", {60'd0, ret1}, 64'd0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        in_rst[i]    = ($urandom_range(39, 0) != 0);
        in_start[i]  = ($urandom_range(3, 0) == 0);
        in_frdy[i]   = ($urandom_range(1, 0) == 0);
        in_ebreak[i] = ($urandom_range(7, 0) == 0);
        in_load[i]   = ($urandom_range(2, 0) == 0);
        in_store[i]  = ($urandom_range(2, 0) == 0);
        in_drdy[i]   = ($urandom_range(2, 0) == 0);
        in_dwrdy[i]  = ($urandom_range(2, 0) == 0);
        in_clr[i]    = ($urandom_range(31, 0) == 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
